// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU (W-cycle logic/add/sub, LSB first)
// Optional overflow flag compiled in with SERIAL_ALU_OVF_EN.
module serial_alu #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_sh, b_sh, res_sh;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            last;
  logic            is_arith;
  logic            a_bit, b_bit;
  logic            bit_out, carry_next;
  logic [W-1:0]    res_final;

  assign last      = (cnt == CW'(W - 1));
  assign is_arith  = (op_q[2:1] == 2'b11);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign res_final = {bit_out, res_sh[W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One-bit slice; SUB feeds ~B with the carry preset to 1
  always_comb begin
    a_bit      = a_sh[0];
    b_bit      = b_sh[0] ^ (op_q == OP_SUB);
    bit_out    = 1'b0;
    carry_next = 1'b0;
    case (op_q)
      OP_AND:  bit_out = a_bit & b_bit;
      OP_OR:   bit_out = a_bit | b_bit;
      OP_XOR:  bit_out = a_bit ^ b_bit;
      OP_NAND: bit_out = ~(a_bit & b_bit);
      OP_NOR:  bit_out = ~(a_bit | b_bit);
      OP_XNOR: bit_out = ~(a_bit ^ b_bit);
      default: begin
        bit_out    = a_bit ^ b_bit ^ carry;
        carry_next = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
      end
    endcase
    if (!is_arith) carry_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op;
            cnt   <= '0;
            carry <= (op == OP_SUB);
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_final;
          carry  <= carry_next;
          cnt    <= cnt + 1'b1;
          if (last) begin
            result <= res_final;
            cout   <= carry_next;
            zero   <= ~|res_final;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  // On the last bit, carry holds the carry into bit W-1
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (state == RUN && last)
      ovf <= is_arith & (carry ^ carry_next);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter W, default 16: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 a  input  W  operand A; captured when start is accepted.
REQ-006 b  input  W  operand B; captured when start is accepted.
REQ-007 op  input  3  opcode; captured when start is accepted: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ADD, 7 SUB.
REQ-008 busy  output  1  high while the operation is being computed.
REQ-009 done  output  1  one-cycle pulse when result and flags become valid.
REQ-010 result  output  W  result of the last completed operation.
REQ-011 cout  output  1  final carry of ADD/SUB; 0 for logic ops.
REQ-012 zero  output  1  high when result is all zeros.
REQ-013 ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after exactly W bit-cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 On acceptance at edge N, the block SHALL capture a, b and op, clear the bit counter, and preset the carry to 1 for SUB and 0 otherwise.
REQ-016 In RUN, each edge SHALL process one bit, LSB first, using a 1-bit full-adder/logic slice selected by op.
- For SUB, the B bit is inverted (A + ~B + 1).
- The produced bit is shifted into the result shift register from the MSB end.
REQ-017 Carry SHALL be updated only for ADD/SUB and held at 0 for logic ops.
REQ-018 busy SHALL be high from edge N through edge N+W, i.e. for exactly W cycles.
REQ-019 At edge N+W, result, cout, zero and ovf SHALL update together, and done SHALL be high for exactly one cycle.
REQ-020 Total latency is W cycles from acceptance to the done cycle; issue rate is one operation per W+2 cycles maximum.
REQ-021 result, cout, zero and ovf SHALL hold their values until the next done; they do not change during RUN.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing. Operand/op input changes after acceptance have no effect.
REQ-023 SUB: cout=1 means no borrow (a >= b unsigned). ADD: cout is the carry out of bit W-1.

Reset
REQ-024 When rst_n=0 at an edge:
- state SHALL become IDLE;
- busy=0, done=0, result=0, cout=0, ovf=0, zero=1;
- bit counter, carry and captured operands are cleared.
REQ-025 Reset SHALL take priority over start and SHALL abort any in-flight operation with no done pulse.
REQ-026 Reset SHALL have no asynchronous effect; outputs change only at a clock edge.

Configuration
REQ-027 Macro SERIAL_ALU_OVF_EN.
- Defined: ovf = carry into bit W-1 XOR carry out of bit W-1, for ADD/SUB only, updated at done; 0 for logic ops.
- Not defined: no overflow logic is compiled in, and ovf is tied to constant 0.
- The port exists in both builds.

Verification (W=16)
REQ-028 ADD a=0xFFFF, b=0x0001, start at edge N -> done only at N+16, result=0x0000, cout=1, zero=1, busy high 16 cycles.
REQ-029 SUB a=0x0005, b=0x0007 -> result=0xFFFE, cout=0, zero=0; SUB a=0x0007, b=0x0007 -> result=0x0000, cout=1, zero=1.
REQ-030 XOR a=0xA5A5, b=0xFFFF -> result=0x5A5A, cout=0; then NOR 0x0000,0x0000 -> result=0xFFFF.
REQ-031 ADD 0x1234+0x1111 accepted; start pulsed with SUB at N+5 while busy -> result=0x2345 at N+16, exactly one done, second request dropped.
REQ-032 rst_n=0 at N+8 mid-ADD -> next cycle busy=0, done=0, result=0x0000, zero=1; no done pulse follows; new start afterwards completes normally.
REQ-033 ADD 0x7FFF+0x0001 -> result=0x8000, ovf=1 with SERIAL_ALU_OVF_EN defined, ovf=0 without it.
